// File: rtl/ysyx_22050019_pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ysyx_22050019_pipe_pkg : shared types and sideband layout for pipe stages
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
package ysyx_22050019_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  // Difftest sideband: four 64-bit CSR slices, LSB offsets within the dbg word.
  localparam int DBG_CSR_W       = 64;
  localparam int DBG_MTVEC_LSB   = 0;
  localparam int DBG_MEPC_LSB    = 64;
  localparam int DBG_MSTATUS_LSB = 128;
  localparam int DBG_MCAUSE_LSB  = 192;

  function automatic logic [1:0] state_occ(input pipe_state_e s);
    case (s)
      BUSY:    state_occ = 2'd1;
      FULL:    state_occ = 2'd2;
      default: state_occ = 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050019_skid_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ysyx_22050019_skid_ctrl : EMPTY/BUSY/FULL control for the 2-entry skid stage
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module ysyx_22050019_skid_ctrl
  import ysyx_22050019_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_in_valid,
  input  logic       i_out_ready,
  input  logic       i_flush,
  output logic       o_in_ready,
  output logic       o_out_valid,
  output logic [1:0] o_occ,
  output logic       o_load_main,
  output logic       o_main_from_skid,
  output logic       o_load_skid
);

  pipe_state_e r_state;
  pipe_state_e w_state_nxt;
  logic        w_in_fire;
  logic        w_out_fire;

  // Handshake outputs depend only on the registered state.
  assign o_out_valid = (r_state != EMPTY);
  assign o_in_ready  = (r_state != FULL);
  assign o_occ       = state_occ(r_state);
  assign w_in_fire   = i_in_valid & o_in_ready;
  assign w_out_fire  = o_out_valid & i_out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    o_load_main      = 1'b0;
    o_main_from_skid = 1'b0;
    o_load_skid      = 1'b0;
    if (i_flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = BUSY;
            o_load_main = 1'b1;
          end
        end
        BUSY: begin
          if (w_in_fire && w_out_fire) begin
            o_load_main = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = FULL;
            o_load_skid = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            w_state_nxt      = BUSY;
            o_load_main      = 1'b1;
            o_main_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_22050019_pipe_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ysyx_22050019_pipe_stage : valid/ready inter-stage register with skid, flush
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module ysyx_22050019_pipe_stage
  import ysyx_22050019_pipe_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int DBG_W          = 256,
  parameter int SKID           = 1,
  parameter int ZERO_ON_BUBBLE = 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [DBG_W-1:0]  in_dbg_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [DBG_W-1:0]  out_dbg_o,
  input  logic              flush_i,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              w_in_ready;
  logic              w_out_valid;
  logic [1:0]        w_occ;
  logic              w_load_main;
  logic              w_main_from_skid;
  logic              w_load_skid;
  logic [DATA_W-1:0] r_main_data;
  logic [DATA_W-1:0] r_skid_data;
  logic [DBG_W-1:0]  r_main_dbg;
  logic [DBG_W-1:0]  r_skid_dbg;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_stall;

  generate
    if (SKID != 0) begin : g_skid
      ysyx_22050019_skid_ctrl u_ctrl (
        .clk              (clk),
        .rst              (rst_n),
        .i_in_valid       (in_valid_i),
        .i_out_ready      (out_ready_i),
        .i_flush          (flush_i),
        .o_in_ready       (w_in_ready),
        .o_out_valid      (w_out_valid),
        .o_occ            (w_occ),
        .o_load_main      (w_load_main),
        .o_main_from_skid (w_main_from_skid),
        .o_load_skid      (w_load_skid)
      );
    end else begin : g_single
      logic r_valid;
      logic w_in_fire;
      logic w_out_fire;

      // Downstream ready passes straight through to upstream here.
      assign w_in_ready  = ~r_valid | out_ready_i;
      assign w_in_fire   = in_valid_i & w_in_ready;
      assign w_out_fire  = r_valid & out_ready_i;

      always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
          r_valid <= 1'b0;
        end else if (flush_i) begin
          r_valid <= 1'b0;
        end else if (w_in_fire) begin
          r_valid <= 1'b1;
        end else if (w_out_fire) begin
          r_valid <= 1'b0;
        end
      end

      assign w_out_valid      = r_valid;
      assign w_occ            = {1'b0, r_valid};
      assign w_load_main      = w_in_fire & ~flush_i;
      assign w_main_from_skid = 1'b0;
      assign w_load_skid      = 1'b0;
    end
  endgenerate

  // Payload and sideband share load enables; flush never clears them.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_main_data <= '0;
      r_main_dbg  <= '0;
      r_skid_data <= '0;
      r_skid_dbg  <= '0;
    end else begin
      if (w_load_main) begin
        r_main_data <= w_main_from_skid ? r_skid_data : in_data_i;
        r_main_dbg  <= w_main_from_skid ? r_skid_dbg  : in_dbg_i;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data_i;
        r_skid_dbg  <= in_dbg_i;
      end
    end
  end

  assign w_stall = w_out_valid & ~out_ready_i;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  generate
    if (ZERO_ON_BUBBLE != 0) begin : g_zero_bubble
      assign out_data_o = w_out_valid ? r_main_data : '0;
    end else begin : g_hold_bubble
      assign out_data_o = r_main_data;
    end
  endgenerate

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = w_out_valid;
  assign out_dbg_o   = r_main_dbg;
  assign occ_o       = w_occ;
  assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire
